texture_fetch: RTL and testbench

Texture fetch stage sitting directly upstream of the 128x128x8 texture RAM. Accepts per-fragment (u, v) texture coordinates in 8.8 fixed point with a side-band tag, converts them to a 14-bit texel address with repeat or clamp addressing, and issues reads to the RAM, whose read data is registered with one cycle of latency. Returns texels in request order through a valid/ready output port with a 4-entry skid FIFO. It also owns the RAM's write port for texture uploads, arbitrated against fetches.

---
 rtl/texture_fetch.sv | 137 +++++++++++++
 tb/tb_texture_fetch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/texture_fetch.sv
// Texture fetch stage: (u,v) 8.8 to texel address, in-order reads from the
// 128x128 texture RAM, skid FIFO on the output, and arbitrated upload port.
module texture_fetch #(
  parameter int TAG_W      = 16,
  parameter bit WRAP       = 1'b1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [15:0]      i_u,
  input  logic [15:0]      i_v,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [7:0]       o_texel,
  output logic [TAG_W-1:0] o_tag,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [13:0]      i_wr_address,
  input  logic [7:0]       i_wr_data,
  output logic [13:0]      o_ram_address,
  output logic [7:0]       o_ram_data,
  output logic             o_ram_write_enable,
  input  logic [7:0]       i_ram_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic             iss_valid;
  logic [13:0]      iss_addr;
  logic [TAG_W-1:0] iss_tag;
  logic             pend_valid;
  logic [TAG_W-1:0] pend_tag;

  logic [7:0]       fifo_texel [FIFO_DEPTH];
  logic [TAG_W-1:0] fifo_tag   [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    fifo_count;

  logic [13:0]      last_addr;
  logic [6:0]       tx;
  logic [6:0]       ty;
  logic [CW:0]      in_flight;
  logic             accept;
  logic             wr_gnt;
  logic             push;
  logic             pop;
  logic             unused_frac;

  assign unused_frac = ^{i_u[7:0], i_v[7:0]};

  // Clamp only saturates integer coords above 127; repeat keeps low 7 bits.
  assign tx = (WRAP || !i_u[15]) ? i_u[14:8] : 7'h7F;
  assign ty = (WRAP || !i_v[15]) ? i_v[14:8] : 7'h7F;

  assign in_flight = {1'b0, fifo_count}
                   + (CW+1)'(iss_valid)
                   + (CW+1)'(pend_valid);

  assign o_ready = ~i_wr_valid
                 & (in_flight < (CW+1)'(FIFO_DEPTH));
  assign accept  = i_valid & o_ready;

  // Gated by reset so an upload is aborted the moment reset asserts.
  assign wr_gnt     = i_wr_valid & ~iss_valid & i_reset_n;
  assign o_wr_ready = wr_gnt;

  assign o_valid = (fifo_count != '0);
  assign o_texel = fifo_texel[rd_ptr];
  assign o_tag   = fifo_tag[rd_ptr];
  assign push    = pend_valid;
  assign pop     = o_valid & i_ready;

  always_comb begin
    o_ram_address      = last_addr;
    o_ram_data         = '0;
    o_ram_write_enable = 1'b0;
    unique case (1'b1)
      iss_valid: o_ram_address = iss_addr;
      wr_gnt: begin
        o_ram_address      = i_wr_address;
        o_ram_data         = i_wr_data;
        o_ram_write_enable = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      iss_valid  <= 1'b0;
      iss_addr   <= '0;
      iss_tag    <= '0;
      pend_valid <= 1'b0;
      pend_tag   <= '0;
      last_addr  <= '0;
    end else begin
      iss_valid  <= accept;
      pend_valid <= iss_valid;
      pend_tag   <= iss_tag;
      last_addr  <= o_ram_address;
      if (accept) begin
        iss_addr <= {ty, tx};
        iss_tag  <= i_tag;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_texel[i] <= '0;
        fifo_tag[i]   <= '0;
      end
    end else begin
      if (push) begin
        fifo_texel[wr_ptr] <= i_ram_data;
        fifo_tag[wr_ptr]   <= pend_tag;
        wr_ptr             <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_texture_fetch.sv
// Bench for texture_fetch: RAM model, shadow texture image and an
// in-order expectation queue built from the addressing rules.
module tb_texture_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, o_ready, o_valid, i_ready;
  logic [15:0] i_u, i_v, i_tag, o_tag;
  logic [7:0]  o_texel;
  logic        i_wr_valid, o_wr_ready;
  logic [13:0] i_wr_address, ram_addr;
  logic [7:0]  i_wr_data, ram_wdata, ram_q;
  logic        ram_we;

  logic        c_valid, c_ready, c_ovalid, c_wr_ready, c_we;
  logic [15:0] c_otag;
  logic [7:0]  c_texel, c_wdata;
  logic [13:0] c_addr;
  logic        c_iready = 1'b1;
  logic        c_wr_valid = 1'b0;
  logic [13:0] c_wr_address = '0;
  logic [7:0]  c_wr_data = '0;
  logic [7:0]  c_ram_q = '0;

  always #5 clk = ~clk;

  texture_fetch #(.TAG_W(16), .WRAP(1'b1), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_u(i_u), .i_v(i_v), .i_tag(i_tag),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_texel(o_texel), .o_tag(o_tag),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_address(i_wr_address), .i_wr_data(i_wr_data),
    .o_ram_address(ram_addr), .o_ram_data(ram_wdata),
    .o_ram_write_enable(ram_we), .i_ram_data(ram_q)
  );

  texture_fetch #(.TAG_W(16), .WRAP(1'b0), .FIFO_DEPTH(4)) dut_clamp (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_valid(c_valid), .o_ready(c_ready),
    .i_u(i_u), .i_v(i_v), .i_tag(i_tag),
    .o_valid(c_ovalid), .i_ready(c_iready),
    .o_texel(c_texel), .o_tag(c_otag),
    .i_wr_valid(c_wr_valid), .o_wr_ready(c_wr_ready),
    .i_wr_address(c_wr_address), .i_wr_data(c_wr_data),
    .o_ram_address(c_addr), .o_ram_data(c_wdata),
    .o_ram_write_enable(c_we), .i_ram_data(c_ram_q)
  );

  function automatic logic [7:0] init_val(int a);
    return 8'(a * 7 + (a >> 7));
  endfunction

  // Texture RAM: registered read, one cycle of latency.
  logic [7:0] ram [16384];
  logic       ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 16384; i++) ram[i] <= init_val(i);
      ram_init <= 1'b1;
    end else if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
    ram_q <= ram[ram_addr];
  end

  int checks = 0;
  int errors = 0;
  logic [7:0]  shadow [16384];
  logic [23:0] q [$];
  logic        last_acc, last_wr;
  logic        prev_acc, prev_stall;
  logic [13:0] prev_addr;
  logic [7:0]  prev_texel;
  logic [15:0] prev_tag;

  function automatic logic [13:0] ref_addr(logic [15:0] u, logic [15:0] v,
                                           bit wrap);
    int ui, vi, x, y;
    ui = int'(u) / 256;
    vi = int'(v) / 256;
    x  = wrap ? ui % 128 : (ui > 127 ? 127 : ui);
    y  = wrap ? vi % 128 : (vi > 127 ? 127 : vi);
    return 14'(y * 128 + x);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [23:0] e;
    @(negedge clk);
    last_acc = i_valid & o_ready;
    last_wr  = o_wr_ready;
    if (prev_acc) begin
      chk("rd_no_we", 32'(ram_we), 32'd0);
      chk("rd_addr", 32'(ram_addr), 32'(prev_addr));
    end
    if (prev_stall) begin
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_hold", {8'd0, o_texel, o_tag}, {8'd0, prev_texel, prev_tag});
    end
    if (last_wr) shadow[i_wr_address] = i_wr_data;
    if (last_acc) begin
      prev_addr = ref_addr(i_u, i_v, 1'b1);
      q.push_back({shadow[prev_addr], i_tag});
    end
    if (o_valid && i_ready) begin
      if (q.size() == 0) begin
        chk("stale_texel", {8'd0, o_texel, o_tag}, 32'hDEAD_BEEF);
      end else begin
        e = q.pop_front();
        chk("texel_order", {8'd0, o_texel, o_tag}, {8'd0, e});
      end
    end
    prev_acc   = last_acc;
    prev_stall = o_valid & ~i_ready;
    prev_texel = o_texel;
    prev_tag   = o_tag;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int budget);
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < budget && (q.size() != 0 || o_valid); k++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int idx, stall_acc, t;
    bit g;
    logic wr_pend;
    for (int i = 0; i < 16384; i++) shadow[i] = init_val(i);
    prev_acc = 0; prev_stall = 0; prev_addr = '0;
    prev_texel = '0; prev_tag = '0;
    rst_n = 1'b0;
    c_valid = 1'b0;

    // Reset held with random inputs
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      i_valid = 1'($urandom); i_ready = 1'($urandom);
      i_u = 16'($urandom); i_v = 16'($urandom); i_tag = 16'($urandom);
      i_wr_valid = 1'($urandom); i_wr_address = 14'($urandom);
      i_wr_data = 8'($urandom);
      #1;
      chk("rst_ovalid", 32'(o_valid), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      chk("rst_out", {8'd0, o_texel, o_tag}, 32'd0);
    end
    i_valid = 0; i_ready = 0; i_wr_valid = 0; i_tag = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_oready", 32'(o_ready), 32'd1);

    // Upload then fetch with latency check
    i_wr_valid = 1; i_wr_address = 14'h0103; i_wr_data = 8'hA5;
    step();
    chk("upl_grant", 32'(last_wr), 32'd1);
    i_wr_valid = 0;
    i_valid = 1; i_u = 16'h0380; i_v = 16'h0200; i_tag = 16'h1234;
    step();
    chk("lat_accept", 32'(last_acc), 32'd1);
    i_valid = 0;
    chk("lat_e0", 32'(o_valid), 32'd0);
    step();
    chk("lat_e1", 32'(o_valid), 32'd0);
    step();
    chk("lat_e2", {7'd0, o_valid, o_texel, o_tag}, {7'd0, 1'b1, 8'hA5, 16'h1234});
    drain(10);

    // Repeat vs clamp addressing
    i_valid = 1; c_valid = 1;
    i_u = 16'h8500; i_v = 16'hFF00; i_tag = 16'h0005;
    step();
    chk("wrap_acc", 32'(last_acc), 32'd1);
    i_valid = 0; c_valid = 0;
    chk("wrap_addr", 32'(ram_addr), 32'h3F85);
    chk("clamp_addr", 32'(c_addr), 32'h3FFF);
    drain(10);

    // Backpressure: 16 requests, 4 credits while stalled
    i_ready = 0; idx = 0; stall_acc = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      i_valid = (idx < 16);
      i_u = 16'($urandom); i_v = 16'($urandom); i_tag = 16'(idx);
      step();
      if (last_acc) begin
        idx++;
        if (cyc < 20) stall_acc++;
      end
      if (cyc == 19) begin
        chk("bp_accepts", 32'(stall_acc), 32'd4);
        chk("bp_oready", 32'(o_ready), 32'd0);
        i_ready = 1;
      end
    end
    chk("bp_all_sent", 32'(idx), 32'd16);
    drain(20);

    // Upload arriving while fetches stream
    i_ready = 1;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1; i_u = 16'($urandom); i_v = 16'($urandom);
      i_tag = 16'($urandom);
      step();
    end
    i_wr_valid = 1; i_wr_address = 14'($urandom); i_wr_data = 8'($urandom);
    #1;
    chk("arb_oready", 32'(o_ready), 32'd0);
    g = 0; t = 0;
    for (int k = 0; k < 3 && !g; k++) begin
      step();
      if (last_wr) begin g = 1; t = k; end
    end
    chk("arb_grant", 32'(g && t <= 1), 32'd1);
    i_wr_valid = 0;
    drain(20);

    // Random mix of fetches, uploads and backpressure
    wr_pend = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      i_valid = 1'($urandom);
      i_ready = ($urandom_range(0, 3) != 0);
      i_u = {8'($urandom_range(0, 7)) | ($urandom_range(0, 1) ? 8'h80 : 8'h00),
             8'($urandom)};
      i_v = {8'($urandom_range(0, 7)) | ($urandom_range(0, 1) ? 8'h80 : 8'h00),
             8'($urandom)};
      i_tag = 16'($urandom);
      if (!wr_pend && $urandom_range(0, 7) == 0) begin
        wr_pend = 1;
        i_wr_address = {7'($urandom_range(0, 7)), 7'($urandom_range(0, 7))};
        i_wr_data = 8'($urandom);
      end
      i_wr_valid = wr_pend;
      step();
      if (last_wr) wr_pend = 0;
    end
    i_wr_valid = 0;
    drain(40);

    // Async reset with three requests in flight
    i_ready = 0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1; i_u = 16'($urandom); i_v = 16'($urandom);
      i_tag = 16'($urandom);
      step();
    end
    i_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ovalid", 32'(o_valid), 32'd0);
    chk("mid_rst_we", 32'(ram_we), 32'd0);
    q.delete();
    prev_acc = 0; prev_stall = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    i_ready = 1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("post_rst_idle", 32'(o_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
